bb_status_rd: RTL



---
 rtl/bb_status_rd.sv | 108 ++++++++++
 1 files changed

// File: rtl/bb_status_rd.sv
// bb_status_rd: collects per-bit event pulses into sticky status bits and
// hands them to a consumer as a snapshot-and-clear read over valid/ready,
// together with a saturating count of event cycles since the last read.
module bb_status_rd #(
  parameter int unsigned    DW      = 8,
  parameter int unsigned    CW      = 4,
  parameter logic [DW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] evt,
  input  logic          rd_req,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] rd_cnt,
  output logic          rd_busy,
  output logic          pending
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [DW-1:0] sticky_q, sticky_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;

  logic any_evt;
  logic capture;
  logic accept;

  assign any_evt = |evt;
  // A request only counts in IDLE; the acceptance cycle itself is in HOLD,
  // so a request coinciding with acceptance is naturally not sampled.
  assign capture = (state_q == IDLE) && rd_req;
  assign accept  = (state_q == HOLD) && rd_valid_q && rd_ready;

  // Next-state and snapshot logic; events landing on the capture edge are
  // OR-ed in after the clear so they show up in the following snapshot.
  always_comb begin
    state_d    = state_q;
    sticky_d   = sticky_q | evt;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_cnt_d   = rd_cnt_q;

    if (any_evt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d    = HOLD;
          rd_data_d  = sticky_q;
          rd_cnt_d   = cnt_q;
          rd_valid_d = 1'b1;
          sticky_d   = evt;
          cnt_d      = any_evt ? CNT_ONE : '0;
        end
      end
      HOLD: begin
        if (accept) begin
          state_d    = IDLE;
          rd_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and snapshot registers; reset discards any read in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sticky_q   <= RST_VAL;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_cnt   = rd_cnt_q;
  assign rd_busy  = (state_q != IDLE);
  assign pending  = |sticky_q;

endmodule
